// File: rtl/hsv_to_rgb_pkg.sv
// Shared constants and types for the HSV-to-RGB colour-space pipeline.
package hsv_to_rgb_pkg;

   localparam int unsigned LATENCY = 3;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned RGB_W   = 3 * PIX_W;
   localparam int unsigned H6_W    = 11;
   localparam int unsigned SEC_W   = 3;

   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(255);

   localparam logic [SEC_W-1:0] SEC_0 = SEC_W'(0);
   localparam logic [SEC_W-1:0] SEC_1 = SEC_W'(1);
   localparam logic [SEC_W-1:0] SEC_2 = SEC_W'(2);
   localparam logic [SEC_W-1:0] SEC_3 = SEC_W'(3);
   localparam logic [SEC_W-1:0] SEC_4 = SEC_W'(4);
   localparam logic [SEC_W-1:0] SEC_5 = SEC_W'(5);

   // Per-slot control that travels alongside pixel data through every stage.
   typedef struct packed {
      logic valid;
      logic hsync;
      logic vsync;
   } side_t;

endpackage

// File: rtl/hsv_to_rgb_if.sv
// Pixel/sideband bundle for the HSV-to-RGB converter; slave is the converter side.
interface hsv_to_rgb_if;
   import hsv_to_rgb_pkg::*;

   logic             in_valid;
   logic [RGB_W-1:0] HSV;
   logic             in_hsync;
   logic             in_vsync;
   logic             out_valid;
   logic [RGB_W-1:0] RGB;
   logic             out_hsync;
   logic             out_vsync;

   modport slave  (input  in_valid, HSV, in_hsync, in_vsync,
                   output out_valid, RGB, out_hsync, out_vsync);
   modport master (output in_valid, HSV, in_hsync, in_vsync,
                   input  out_valid, RGB, out_hsync, out_vsync);
endinterface

// File: rtl/hsv_mul8.sv
// Unsigned 8x8 multiply returning the upper byte of the 16-bit product (a*b >> 8).
module hsv_mul8
   import hsv_to_rgb_pkg::*;
(
   input  logic [PIX_W-1:0] a,
   input  logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] prodHi_c
);

   assign prodHi_c = PIX_W'((16'(a) * 16'(b)) >> PIX_W);

endmodule

// File: rtl/hsv_to_rgb.sv
// Three-stage HSV-to-RGB converter with clock-enable and sideband alignment.
module hsv_to_rgb
   import hsv_to_rgb_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ce,
   hsv_to_rgb_if.slave  bus
);

   logic [PIX_W-1:0] hIn, sIn, vIn;
   logic [H6_W-1:0]  h6;

   assign {hIn, sIn, vIn} = bus.HSV;
   assign h6 = H6_W'(hIn) * H6_W'(6);

   side_t            s1Side;
   logic [SEC_W-1:0] s1Sector;
   logic [PIX_W-1:0] s1F, s1S, s1V;

   // Stage 1: hue scaled to six sectors; upper bits select sector, low byte is the fraction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1Side   <= '0;
         s1Sector <= '0;
         s1F      <= '0;
         s1S      <= '0;
         s1V      <= '0;
      end else if (ce) begin
         s1Side   <= '{valid: bus.in_valid, hsync: bus.in_hsync, vsync: bus.in_vsync};
         s1Sector <= h6[H6_W-1:PIX_W];
         s1F      <= h6[PIX_W-1:0];
         s1S      <= sIn;
         s1V      <= vIn;
      end
   end

   logic [PIX_W-1:0] sf_c, sfn_c;

   hsv_mul8 uMulSf  (.a(s1S), .b(s1F),           .prodHi_c(sf_c));
   hsv_mul8 uMulSfn (.a(s1S), .b(PIX_MAX - s1F), .prodHi_c(sfn_c));

   side_t            s2Side;
   logic [SEC_W-1:0] s2Sector;
   logic [PIX_W-1:0] s2Sf, s2Sfn, s2Ns, s2V;
   logic             s2Bypass;

   // Stage 2: saturation-weighted fractions; zero saturation flags a grey pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2Side   <= '0;
         s2Sector <= '0;
         s2Sf     <= '0;
         s2Sfn    <= '0;
         s2Ns     <= '0;
         s2V      <= '0;
         s2Bypass <= 1'b0;
      end else if (ce) begin
         s2Side   <= s1Side;
         s2Sector <= s1Sector;
         s2Sf     <= sf_c;
         s2Sfn    <= sfn_c;
         s2Ns     <= PIX_MAX - s1S;
         s2V      <= s1V;
         s2Bypass <= (s1S == '0);
      end
   end

   logic [PIX_W-1:0] p_c, q_c, t_c;
   logic [RGB_W-1:0] rgbNext;

   hsv_mul8 uMulP (.a(s2V), .b(s2Ns),            .prodHi_c(p_c));
   hsv_mul8 uMulQ (.a(s2V), .b(PIX_MAX - s2Sf),  .prodHi_c(q_c));
   hsv_mul8 uMulT (.a(s2V), .b(PIX_MAX - s2Sfn), .prodHi_c(t_c));

   // Sector-to-channel mapping; sector codes 6 and 7 cannot arise from an 8-bit hue.
   always_comb begin
      rgbNext = '0;
      if (s2Bypass) begin
         rgbNext = {s2V, s2V, s2V};
      end else begin
         case (s2Sector)
            SEC_0:   rgbNext = {s2V, t_c, p_c};
            SEC_1:   rgbNext = {q_c, s2V, p_c};
            SEC_2:   rgbNext = {p_c, s2V, t_c};
            SEC_3:   rgbNext = {p_c, q_c, s2V};
            SEC_4:   rgbNext = {t_c, p_c, s2V};
            SEC_5:   rgbNext = {s2V, p_c, q_c};
            default: rgbNext = '0;
         endcase
      end
   end

   // Stage 3: RGB only loads on valid slots so it holds across bubbles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid <= 1'b0;
         bus.out_hsync <= 1'b0;
         bus.out_vsync <= 1'b0;
         bus.RGB       <= '0;
      end else if (ce) begin
         bus.out_valid <= s2Side.valid;
         bus.out_hsync <= s2Side.hsync;
         bus.out_vsync <= s2Side.vsync;
         if (s2Side.valid) begin
            bus.RGB <= rgbNext;
         end
      end
   end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: driver queues expected slots, monitor checks each ce edge.
module tb_hsv_to_rgb;
   import hsv_to_rgb_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   logic ce;

   hsv_to_rgb_if bus ();

   hsv_to_rgb dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
      int          edgeN;
   } exp_t;

   exp_t expQ[$];
   int   ceCnt  = 0;
   int   checks = 0;
   int   passes = 0;

   logic [23:0] vHsv [0:8];
   logic [23:0] vRgb [0:8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, required %h (ce edge %0d)", name, act, req, ceCnt);
   endtask

   // Monitor: counts ce-enabled edges and compares outputs mid-cycle.
   logic        ceS, rstS;
   logic        prevV, prevHs, prevVs;
   logic [23:0] prevRgb;
   always begin
      exp_t e;
      @(posedge clk);
      ceS  = ce;
      rstS = reset_n;
      if (ce === 1'b1 && reset_n === 1'b1) ceCnt++;
      @(negedge clk);
      if (rstS === 1'b1 && reset_n === 1'b1) begin
         if (ceS) begin
            if (expQ.size() > 0 && expQ[0].edgeN == ceCnt) begin
               e = expQ.pop_front();
               check("ctl", 32'({bus.out_valid, bus.out_hsync, bus.out_vsync}),
                     32'({e.valid, e.hs, e.vs}));
               if (e.valid) check("rgb", 32'(bus.RGB), 32'(e.rgb));
            end else begin
               check("idle", 32'({bus.out_valid, bus.out_hsync, bus.out_vsync}), 32'(0));
            end
         end else begin
            check("hold", 32'({bus.out_valid, bus.out_hsync, bus.out_vsync, bus.RGB}),
                  32'({prevV, prevHs, prevVs, prevRgb}));
         end
      end
      prevV   = bus.out_valid;
      prevHs  = bus.out_hsync;
      prevVs  = bus.out_vsync;
      prevRgb = bus.RGB;
   end

   task automatic pushExp(input bit v, input bit hs, input bit vs, input logic [23:0] rgb);
      exp_t e;
      e.valid = v;
      e.hs    = hs;
      e.vs    = vs;
      e.rgb   = rgb;
      e.edgeN = ceCnt + int'(LATENCY);
      expQ.push_back(e);
   endtask

   task automatic issue(input bit c, input bit v, input bit hs, input bit vs,
                        input logic [23:0] hsv, input logic [23:0] rgb);
      @(posedge clk);
      #1;
      ce           = c;
      bus.in_valid = v;
      bus.in_hsync = hs;
      bus.in_vsync = vs;
      bus.HSV      = hsv;
      if (c && (v || hs || vs)) pushExp(v, hs, vs, rgb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      vHsv[0] = 24'h00FFFF; vRgb[0] = 24'hFF0000;
      vHsv[1] = 24'h55FFFF; vRgb[1] = 24'h01FF00;
      vHsv[2] = 24'h80FFC8; vRgb[2] = 24'h00C7C8;
      vHsv[3] = 24'hFFFFFF; vRgb[3] = 24'hFF0005;
      vHsv[4] = 24'h2BFFFF; vRgb[4] = 24'hFDFF00;
      vHsv[5] = 24'hAAFFFF; vRgb[5] = 24'h0003FF;
      vHsv[6] = 24'hC880FF; vRgb[6] = 24'hD77EFF;
      vHsv[7] = 24'h64C896; vRgb[7] = 24'h209649;
      vHsv[8] = 24'h1E6450; vRgb[8] = 24'h504630;

      reset_n      = 1'b1;
      ce           = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_hsync = 1'b0;
      bus.in_vsync = 1'b0;
      bus.HSV      = '0;
      #1 reset_n = 1'b0;
      #1;
      check("rst_ctl", 32'({bus.out_valid, bus.out_hsync, bus.out_vsync}), 32'(0));
      check("rst_rgb", 32'(bus.RGB), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      ce      = 1'b1;

      // Isolated pixels, each followed by idle slots.
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[i], vRgb[i]);
         idle(4);
      end

      // Back-to-back over the remaining directed vectors.
      for (int i = 3; i < 9; i++) issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[i], vRgb[i]);
      idle(4);

      // Grey bypass at several hues.
      issue(1'b1, 1'b1, 1'b0, 1'b0, 24'h000064, 24'h646464);
      issue(1'b1, 1'b1, 1'b0, 1'b0, 24'h800064, 24'h646464);
      issue(1'b1, 1'b1, 1'b0, 1'b0, 24'hFF0064, 24'h646464);
      idle(4);

      // Eight-pixel stream with a four-cycle ce-low window mid-flight.
      issue(1'b1, 1'b1, 1'b0, 1'b1, vHsv[0], vRgb[0]);
      issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[1], vRgb[1]);
      issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[2], vRgb[2]);
      for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 1'b0, 1'b0, vHsv[3], vRgb[3]);
      for (int i = 3; i < 8; i++) issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[i], vRgb[i]);
      idle(4);

      // Bubble carrying an hsync pulse between two valid pixels.
      issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[4], vRgb[4]);
      issue(1'b1, 1'b0, 1'b1, 1'b0, vHsv[6], 24'h0);
      issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[5], vRgb[5]);
      idle(4);

      // Reset pulse with pixels in flight; first pixel after release must come out alone.
      issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[0], vRgb[0]);
      issue(1'b1, 1'b1, 1'b0, 1'b0, vHsv[7], vRgb[7]);
      issue(1'b1, 1'b1, 1'b1, 1'b0, vHsv[8], vRgb[8]);
      idle(1);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_ctl", 32'({bus.out_valid, bus.out_hsync, bus.out_vsync}), 32'(0));
      check("midrst_rgb", 32'(bus.RGB), 32'(0));
      expQ.delete();
      @(posedge clk);
      #1;
      reset_n      = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_hsync = 1'b0;
      bus.in_vsync = 1'b0;
      bus.HSV      = vHsv[6];
      pushExp(1'b1, 1'b0, 1'b0, vRgb[6]);
      idle(6);

      for (int i = 0; i < 20 && expQ.size() > 0; i++) idle(1);
      check("drain", 32'(expQ.size()), 32'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hsv_to_rgb.md
HSV_TO_RGB -- requirements
Module: hsv_to_rgb

Interface
REQ-001 The block SHALL have no parameters; the pipeline depth is fixed at 3 (LATENCY, shared package).
REQ-002 Port clk, input, 1 bit: the single clock; all registers SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 Port ce, input, 1 bit: pipeline clock-enable; when low, every stage SHALL hold.
REQ-005 Port in_valid, input, 1 bit: HSV pixel on the input is valid.
REQ-006 Port HSV, input, 24 bits: {H[23:16], S[15:8], V[7:0]}, unsigned 8-bit each; H 0..255 spans one full hue circle.
REQ-007 Port in_hsync, input, 1 bit; port in_vsync, input, 1 bit: video sideband.
REQ-008 Port out_valid, output, 1 bit: RGB output is valid.
REQ-009 Port RGB, output, 24 bits: {R[23:16], G[15:8], B[7:0]}.
REQ-010 Port out_hsync, output, 1 bit; port out_vsync, output, 1 bit: sideband delayed to match RGB.

Function
REQ-011 Each output SHALL appear exactly 3 ce-enabled clk edges after its input was sampled with ce=1.
REQ-012 in_valid, in_hsync and in_vsync SHALL travel through the same 3 stages as the pixel data, never skewed.
REQ-013 Stage 1 SHALL register h6 = H*6 (11 bits), sector = h6[10:8] (0..5), f = h6[7:0], S, V, and sideband.
REQ-014 Stage 2 SHALL register sf = (S*f)>>8, sfn = (S*(255-f))>>8, and ns = 255-S, all 8 bits.
REQ-015 Stage 2 SHALL also carry sector, V, a bypass flag (S==0) and sideband.
REQ-016 Stage 3 SHALL compute p = (V*ns)>>8, q = (V*(255-sf))>>8 and t = (V*(255-sfn))>>8, each truncated, 16-bit intermediates.
REQ-017 Stage 3 RGB mapping: sector0 (V,t,p), 1 (q,V,p), 2 (p,V,t), 3 (p,q,V), 4 (t,p,V), 5 (V,p,q).
REQ-018 When bypass is set, RGB SHALL equal (V,V,V), regardless of H.
REQ-019 H=255 SHALL give sector 5, f=250; no sector value of 6 or 7 SHALL ever be produced.
REQ-020 RGB SHALL be registered and SHALL hold its last value while out_valid=0; no output path is combinational.
REQ-021 Invalid slots SHALL propagate as bubbles (out_valid=0), and their data contents are don't-care.
REQ-022 With ce=0, outputs SHALL be stable; a ce=0 window of any length SHALL NOT drop or duplicate pixels.

Reset
REQ-023 reset_n=0 SHALL immediately clear all stage valid bits, out_valid, out_hsync and out_vsync to 0, and RGB to 24'h000000.
REQ-024 Reset mid-stream SHALL discard every in-flight pixel; the first post-reset output is the pixel sampled on the first ce edge after release.
REQ-025 Reset release need not be synchronized inside the block; synchronization is upstream's responsibility.

Structure
REQ-026 A shared package SHALL hold LATENCY=3, the sector encodings SEC_0..SEC_5 (3 bits), and the pixel-width constant 8.
REQ-027 One sub-module, hsv_mul8, SHALL be instantiated: an unsigned 8x8->16 multiplier returning the product >>8.
REQ-028 hsv_mul8 SHALL be purely combinational; the parent SHALL register its result.
REQ-029 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-030 Pure red: H=0, S=255, V=255, valid -> 3 cycles later RGB=24'hFF0000, out_valid=1.
REQ-031 Sector 1: H=85, S=255, V=255 -> RGB=(1,255,0). Sector 3: H=128, S=255, V=200 -> RGB=(0,199,200).
REQ-032 Grey bypass: S=0, V=100, H in {0,128,255} -> RGB=(100,100,100) each.
REQ-033 Streaming with ce: 8 back-to-back pixels, ce low for cycles 3-6 -> 8 outputs in order, none lost or duplicated, RGB stable while ce=0.
REQ-034 Sideband/bubbles: in_valid pattern 1,0,1 with hsync pulse on pixel 2 -> out_valid 1,0,1 and out_hsync aligned to the same slot.
REQ-035 Reset mid-flight: reset_n low for one cycle with 3 pixels in flight -> out_valid=0 and RGB=0 immediately; no stale pixel appears afterward.
